demod_segment_correlator: RTL and testbench

Parametrised successor to the fixed ten-segment, Q16.16 demodulation segment stage. It accepts a frame of `NSEG` segments, each `SPS` signed samples long, as a valid/ready stream. Each segment is correlated against a ±1.0 reference chip pattern, which is mathematically the same as choosing between `ref` and its negation `ref_m`. The result is a hard-decision bit per segment, returned as a packed vector under a start/valid/busy handshake. It sits between the sample front end and the frame/bit unpacker in the modulation pipe.

---
 rtl/demod_segment_correlator_pkg.sv | 39 +++
 rtl/demod_segment_correlator_if.sv | 60 ++++++
 rtl/demod_segment_correlator_segment_accumulator.sv | 52 +++++
 rtl/demod_segment_correlator.sv | 154 +++++++++++++++
 tb/tb_demod_segment_correlator.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/demod_segment_correlator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : demod_pkg                                                  |
// | Description : Shared types and constant helpers for the demodulation     |
// |               segment correlator (FSM states, widths, Q-format values).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package demod_pkg;

  // Frame-level controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } demod_state_t;

  // Accumulator width able to hold SPS signed terms of width w, including
  // the negation of the most negative sample, without wrapping.
  function automatic int acc_width(input int w, input int sps);
    return w + $clog2(sps + 1) + 1;
  endfunction

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // +1.0 in Q(frac) format
  function automatic longint Q_ONE(input int frac);
    return longint'(1) << frac;
  endfunction

  // -1.0 in Q(frac) format
  function automatic longint Q_MINUS_ONE(input int frac);
    return -Q_ONE(frac);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demod_segment_correlator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : demod_segment_correlator_if                                |
// | Description : Sample stream and decision handshake of the correlator.    |
// |               Metric signals exist only with DEMOD_SOFT_METRIC_EN.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface demod_segment_correlator_if
`ifdef DEMOD_SOFT_METRIC_EN
  #(parameter int W = 32, parameter int NSEG = 10, parameter int SPS = 1);
`else
  #(parameter int W = 32, parameter int NSEG = 10);
`endif
  import demod_pkg::*;

  logic                  start;
  logic signed [W-1:0]   sample_in;
  logic                  sample_valid;
  logic                  sample_ready;
  logic [NSEG-1:0]       bits_out;
  logic                  valid;
  logic                  busy;

`ifdef DEMOD_SOFT_METRIC_EN
  localparam int ACC_W = acc_width(W, SPS);
  localparam int SEG_W = idx_width(NSEG);

  logic signed [ACC_W-1:0] metric_out;
  logic [SEG_W-1:0]        metric_seg;
  logic                    metric_valid;

  // Source of samples / consumer of decisions
  modport master (
    output start, sample_in, sample_valid,
    input  sample_ready, bits_out, valid, busy,
    input  metric_out, metric_seg, metric_valid
  );

  // The correlator itself
  modport slave (
    input  start, sample_in, sample_valid,
    output sample_ready, bits_out, valid, busy,
    output metric_out, metric_seg, metric_valid
  );
`else
  // Source of samples / consumer of decisions
  modport master (
    output start, sample_in, sample_valid,
    input  sample_ready, bits_out, valid, busy
  );

  // The correlator itself
  modport slave (
    input  start, sample_in, sample_valid,
    output sample_ready, bits_out, valid, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/demod_segment_correlator_segment_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : segment_accumulator                                        |
// | Description : Per-segment datapath: chip sign select, running sum,       |
// |               clear, and hard decision (sum > 0) on the final term.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module segment_accumulator #(
  parameter int W     = 32,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept,
  input  logic                    ref_bit,
  input  logic                    last,
  input  logic signed [W-1:0]     sample_in,
  output logic signed [ACC_W-1:0] sum,
  output logic                    decision
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;

  // Sign-extend the sample, then negate it for a -1.0 chip; the extra
  // accumulator bits make the negation of the most negative sample exact.
  always_comb begin
    term = {{(ACC_W-W){sample_in[W-1]}}, sample_in};
    if (!ref_bit) begin
      term = -term;
    end
  end

  assign sum = acc + term;

  // Strictly positive wins; a tie at zero resolves towards ref_m.
  assign decision = !sum[ACC_W-1] && (sum != '0);

  // Running correlation, emptied at frame entry and after each segment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/demod_segment_correlator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demod_segment_correlator                                   |
// | Description : Correlates NSEG segments of SPS samples against a +/-1.0   |
// |               chip pattern and returns one hard-decision bit per segment.|
// |               Optional soft metrics: define DEMOD_SOFT_METRIC_EN.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module demod_segment_correlator
  import demod_pkg::*;
#(
  parameter int             W           = 32,
  parameter int             FRAC        = 16,
  parameter int             NSEG        = 10,
  parameter int             SPS         = 1,
  parameter logic [SPS-1:0] REF_PATTERN = {SPS{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  demod_segment_correlator_if.slave    bus
);

  localparam int             ACC_W       = acc_width(W, SPS);
  localparam int             CNT_W       = idx_width(SPS);
  localparam int             SEG_W       = idx_width(NSEG);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SPS - 1);
  localparam logic [SEG_W-1:0] LAST_SEG    = SEG_W'(NSEG - 1);

  // Reject configurations that cannot work at elaboration time
  if (NSEG < 1 || SPS < 1 || FRAC < 0 || FRAC >= W) begin : g_param_check
    $error("demod_segment_correlator: illegal NSEG/SPS/FRAC configuration");
  end

  demod_state_t      state;
  demod_state_t      state_next;
  logic [CNT_W-1:0]  sample_cnt;
  logic [SEG_W-1:0]  seg_cnt;
  logic [NSEG-1:0]   bits_q;
  logic              accept;
  logic              last_sample;
  logic              ref_bit;
  logic              decision;

  assign accept      = bus.sample_valid && (state == ST_ACC);
  assign last_sample = (sample_cnt == LAST_SAMPLE);

  assign bus.sample_ready = (state == ST_ACC);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.valid        = (state == ST_DONE);
  assign bus.bits_out     = bits_q;

  // Select the reference chip for the current sample position
  always_comb begin
    ref_bit = 1'b0;
    for (int k = 0; k < SPS; k++) begin
      if (sample_cnt == CNT_W'(k)) begin
        ref_bit = REF_PATTERN[k];
      end
    end
  end

`ifdef DEMOD_SOFT_METRIC_EN
  logic signed [ACC_W-1:0] seg_sum;
`endif

  segment_accumulator #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_seg_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == ST_IDLE),
    .accept    (accept),
    .ref_bit   (ref_bit),
    .last      (last_sample),
    .sample_in (bus.sample_in),
`ifdef DEMOD_SOFT_METRIC_EN
    .sum       (seg_sum),
`else
    .sum       (),
`endif
    .decision  (decision)
  );

  // Controller state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start only counts in IDLE; DONE lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_ACC;
      ST_ACC:  if (accept && last_sample && (seg_cnt == LAST_SEG)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample/segment counters; held at zero in IDLE so ACC always starts clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      seg_cnt    <= '0;
    end else if (state == ST_IDLE) begin
      sample_cnt <= '0;
      seg_cnt    <= '0;
    end else if (accept) begin
      if (last_sample) begin
        sample_cnt <= '0;
        seg_cnt    <= seg_cnt + 1'b1;
      end else begin
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  // Decision register: only the current segment's bit changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
    end else if (accept && last_sample) begin
      for (int j = 0; j < NSEG; j++) begin
        if (seg_cnt == SEG_W'(j)) begin
          bits_q[j] <= decision;
        end
      end
    end
  end

`ifdef DEMOD_SOFT_METRIC_EN
  // Soft metric of each segment, presented the cycle after its decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.metric_out   <= '0;
      bus.metric_seg   <= '0;
      bus.metric_valid <= 1'b0;
    end else begin
      bus.metric_valid <= accept && last_sample;
      if (accept && last_sample) begin
        bus.metric_out <= seg_sum;
        bus.metric_seg <= seg_cnt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demod_segment_correlator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_demod_segment_correlator                                |
// | Description : Scoreboard bench, NSEG=4 SPS=4 REF=4'b0101 W=32 FRAC=16.    |
// |               Covers DEMOD_SOFT_METRIC_EN when that macro is defined.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_demod_segment_correlator;
  import demod_pkg::*;

  localparam int         NS   = 4;
  localparam int         SP   = 4;
  localparam int         NSMP = NS * SP;
  localparam logic [3:0] REF  = 4'b0101;
  localparam logic signed [31:0] P1 = 32'(Q_ONE(16));
  localparam logic signed [31:0] M1 = 32'(Q_MINUS_ONE(16));

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  logic signed [31:0] frame_s [NSMP];
  logic [3:0]         exp_bits_q [$];
  longint             exp_cyc_q  [$];
`ifdef DEMOD_SOFT_METRIC_EN
  longint             exp_met_q  [$];
  int                 exp_mseg_q [$];
`endif

`ifdef DEMOD_SOFT_METRIC_EN
  demod_segment_correlator_if #(.W(32), .NSEG(NS), .SPS(SP)) bus ();
`else
  demod_segment_correlator_if #(.W(32), .NSEG(NS)) bus ();
`endif

  demod_segment_correlator #(
    .W(32), .FRAC(16), .NSEG(NS), .SPS(SP), .REF_PATTERN(REF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: signed sum of sample times chip (+1/-1), straight arithmetic
  function automatic longint seg_corr(input int seg);
    longint c = 0;
    for (int k = 0; k < SP; k++) begin
      if (REF[k]) c += longint'(frame_s[seg*SP + k]);
      else        c -= longint'(frame_s[seg*SP + k]);
    end
    return c;
  endfunction

  function automatic logic [3:0] frame_bits();
    logic [3:0] b;
    for (int s = 0; s < NS; s++) b[s] = (seg_corr(s) > 0);
    return b;
  endfunction

  task automatic load_matched_inverted();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < SP; k++)
        frame_s[s*SP + k] = ((k % 2 == 0) ^ (s % 2 == 1)) ? P1 : M1;
  endtask

  task automatic load_random();
    for (int i = 0; i < NSMP; i++) begin
      case ($urandom_range(3))
        0: frame_s[i] = $urandom;
        1: frame_s[i] = int'($urandom_range(200000)) - 100000;
        2: frame_s[i] = 32'sd0;
        default: frame_s[i] = $urandom_range(1) ? P1 : M1;
      endcase
    end
  endtask

  // Drive one frame; optionally abort with reset after abort_after accepts
  task automatic send_frame(input int bubble_pct, input bit do_start,
                            input bit hold_start, input int abort_after);
    int idx = 0;
    int guard = 0;
    bit acc_now;
    if (do_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.sample_valid = 1'b0;
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
    end
    while (idx < NSMP && guard < 1000) begin
      if (abort_after >= 0 && idx == abort_after) begin
        bus.sample_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_bits_out", bus.bits_out, 0);
        chk("abort_ready", bus.sample_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      chk("ready_in_acc", bus.sample_ready, 1);
      bus.sample_valid = ($urandom_range(99) >= bubble_pct);
      bus.sample_in    = frame_s[idx];
      acc_now = bus.sample_valid && bus.sample_ready;
      if (acc_now) begin
`ifdef DEMOD_SOFT_METRIC_EN
        if (idx % SP == SP - 1) begin
          exp_met_q.push_back(seg_corr(idx / SP));
          exp_mseg_q.push_back(idx / SP);
        end
`endif
        if (idx == NSMP - 1 && abort_after < 0) begin
          exp_bits_q.push_back(frame_bits());
          exp_cyc_q.push_back(cyc + 1);
        end
        idx++;
      end
      guard++;
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    if (guard >= 1000) chk("frame_timeout", guard, 0);
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) begin
        if (exp_bits_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("bits_out", bus.bits_out, exp_bits_q.pop_front());
          chk("valid_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (!bus.busy || bus.valid) chk("ready_outside_acc", bus.sample_ready, 0);
`ifdef DEMOD_SOFT_METRIC_EN
      if (bus.metric_valid) begin
        if (exp_met_q.size() == 0) begin
          chk("unexpected_metric", 1, 0);
        end else begin
          chk("metric_out", longint'(bus.metric_out), exp_met_q.pop_front());
          chk("metric_seg", bus.metric_seg, exp_mseg_q.pop_front());
        end
      end
`endif
    end
  end

  initial begin
    int drain;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_bits_out", bus.bits_out, 0);
    chk("reset_valid", bus.valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ready", bus.sample_ready, 0);

    // Matched/inverted frame, no bubbles
    load_matched_inverted();
    send_frame(0, 1'b1, 1'b0, -1);
    repeat (2) @(negedge clk);

    // Abort mid-frame after 6 samples, then a clean frame
    load_random();
    send_frame(0, 1'b1, 1'b0, 6);
    repeat (2) @(negedge clk);
    load_random();
    send_frame(0, 1'b1, 1'b0, -1);
    repeat (2) @(negedge clk);

    // Ties and extremes: zero segment, four 0x80000000, mixed extremes
    for (int i = 0; i < SP; i++) begin
      frame_s[i]        = 32'sd0;
      frame_s[SP + i]   = 32'sh80000000;
      frame_s[2*SP + i] = $urandom;
      frame_s[3*SP + i] = (i % 2 == 0) ? 32'sh7FFFFFFF : 32'sh80000000;
    end
    send_frame(0, 1'b1, 1'b0, -1);
    repeat (2) @(negedge clk);

    // Bubbles over the matched/inverted frame, then random frames
    load_matched_inverted();
    send_frame(40, 1'b1, 1'b0, -1);
    repeat (2) @(negedge clk);
    for (int f = 0; f < 6; f++) begin
      load_random();
      send_frame(30, 1'b1, 1'b0, -1);
      repeat ($urandom_range(3) + 1) @(negedge clk);
    end

    // Start held high for a whole frame: one valid, restart two cycles later
    load_matched_inverted();
    send_frame(0, 1'b1, 1'b1, -1);
    @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
    @(negedge clk);
    chk("restart_ready", bus.sample_ready, 1);
    bus.start = 1'b0;
    load_random();
    send_frame(20, 1'b0, 1'b0, -1);

    drain = 0;
    while ((exp_bits_q.size() != 0) && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    @(negedge clk);
    chk("missing_valid", exp_bits_q.size(), 0);
`ifdef DEMOD_SOFT_METRIC_EN
    chk("missing_metric", exp_met_q.size(), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
